// File: rtl/cmos_cfg_pkg.sv
// rtl/cmos_cfg_pkg.sv - shared types and constants for the camera configuration controller
//
// Purpose: controller state encoding, table word type and the delay-marker address.
// Ports:   none (package).

package cmos_cfg_pkg;

  localparam int TBL_W = 24;

  // A table entry with this register address is a pause, not a bus write.
  localparam logic [15:0] DLY_MARK = 16'hFFFF;

  typedef logic [TBL_W-1:0] tbl_word_t;

  typedef enum logic [2:0] {
    ST_PWDN   = 3'd0,
    ST_RSTL   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_FETCH  = 3'd3,
    ST_DELAY  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } cfg_state_t;

endpackage

// File: rtl/cmos_cfg_ctrl_if.sv
// rtl/cmos_cfg_ctrl_if.sv - write-request handshake between the controller and the SCCB master
//
// Purpose: bundles the single-write request/response signals.
// Signals: i2c_exec (1-cycle request), i2c_data ({reg_addr, reg_val}),
//          i2c_done (1-cycle completion), i2c_nack (valid with i2c_done).
// Modports: master = controller side, slave = SCCB master side.

interface cmos_cfg_ctrl_if;
  import cmos_cfg_pkg::*;

  logic      i2c_exec;
  tbl_word_t i2c_data;
  logic      i2c_done;
  logic      i2c_nack;

  modport master (
    output i2c_exec,
    output i2c_data,
    input  i2c_done,
    input  i2c_nack
  );

  modport slave (
    input  i2c_exec,
    input  i2c_data,
    output i2c_done,
    output i2c_nack
  );

endinterface

// File: rtl/cmos_cfg_rom.sv
// rtl/cmos_cfg_rom.sv - sensor register table (RGB565 output, QVGA, PLL)
//
// Purpose: combinational index -> {reg_addr[15:0], reg_val[7:0]} lookup.
// Ports:   i_idx  - table index
//          o_data - table word for i_idx

module cmos_cfg_rom
  import cmos_cfg_pkg::*;
(
  input  logic [7:0] i_idx,
  output tbl_word_t  o_data
);

  always_comb begin
    // Unused slots are zero-length delays, so a long REG_NUM walks past
    // them without touching the sensor.
    o_data = {DLY_MARK, 8'h00};
    case (i_idx)
      8'd0:  o_data = 24'h3103_11;  // system clock from pad
      8'd1:  o_data = 24'h3008_82;  // software reset
      8'd2:  o_data = {DLY_MARK, 8'd3};  // let the sensor come out of soft reset
      8'd3:  o_data = 24'h3008_42;  // hold in power-down while configuring
      8'd4:  o_data = 24'h3103_03;  // clock from PLL
      8'd5:  o_data = 24'h3017_FF;  // data/sync pins as outputs
      8'd6:  o_data = 24'h3018_FF;
      8'd7:  o_data = 24'h3034_1A;  // PLL setup
      8'd8:  o_data = 24'h3035_21;
      8'd9:  o_data = 24'h3036_46;
      8'd10: o_data = 24'h3037_13;
      8'd11: o_data = 24'h4300_61;  // RGB565
      8'd12: o_data = 24'h501F_01;  // ISP RGB format mux
      8'd13: o_data = 24'h3808_01;  // output width 320
      8'd14: o_data = 24'h3809_40;
      8'd15: o_data = 24'h380A_00;  // output height 240
      8'd16: o_data = 24'h380B_F0;
      8'd17: o_data = 24'h3008_02;  // wake up
      default: ;
    endcase
  end

endmodule

// File: rtl/cmos_cfg_ctrl.sv
// rtl/cmos_cfg_ctrl.sv - camera power-up sequencer and register-table writer
//
// Purpose: drives sensor pwdn/reset pins through power-up, then writes every
//          table entry over SCCB with NACK retry; raises init_done at the end.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          cfg_start     - pulse: rerun the table from DONE or ERR
//          cam_pwdn      - sensor power-down pin
//          cam_rst_n     - sensor reset pin
//          init_done     - table completed
//          cfg_err       - retries exhausted on cfg_idx
//          cfg_idx       - current table index
//          i2c           - write handshake to the SCCB master

module cmos_cfg_ctrl
  import cmos_cfg_pkg::*;
#(
  parameter int         PWDN_CYC   = 300000,
  parameter int         RST_CYC    = 100000,
  parameter int         SETTLE_CYC = 1000000,
  parameter logic [7:0] REG_NUM    = 8'd250,
  parameter logic [2:0] MAX_RETRY  = 3'd3,
  parameter int         DLY_UNIT   = 50000,
  parameter int         CNT_W      = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  output logic                   cam_pwdn,
  output logic                   cam_rst_n,
  output logic                   init_done,
  output logic                   cfg_err,
  output logic [7:0]             cfg_idx,
  cmos_cfg_ctrl_if.master        i2c
);

  // Timed states load N-1 on entry and leave when the counter reads zero,
  // so each lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LD_PWDN   = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_UNIT_C = CNT_W'(DLY_UNIT);

  cfg_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_idx, w_idx_nxt;
  logic [2:0]       r_retry, w_retry_nxt;
  logic             r_exec, w_exec_nxt;
  tbl_word_t        r_data, w_data_nxt;
  logic             r_pwdn, r_rst_n, r_init_done, r_cfg_err;

  tbl_word_t        w_rom;
  logic [CNT_W-1:0] w_dly_cyc;
  logic             w_adv;

  cmos_cfg_rom u_rom (
    .i_idx  (r_idx),
    .o_data (w_rom)
  );

  assign w_dly_cyc = CNT_W'(w_rom[7:0]) * DLY_UNIT_C;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_retry_nxt = r_retry;
    w_exec_nxt  = 1'b0;
    w_data_nxt  = r_data;
    w_adv       = 1'b0;

    case (r_state)
      ST_PWDN: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RSTL;
          w_cnt_nxt   = LD_RST;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RSTL: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = LD_SETTLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_FETCH;
          w_idx_nxt   = 8'd0;
          w_retry_nxt = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_FETCH: begin
        if (w_rom[23:8] == DLY_MARK) begin
          w_state_nxt = ST_DELAY;
          w_cnt_nxt   = w_dly_cyc;
        end else begin
          w_state_nxt = ST_WAIT;
          w_exec_nxt  = 1'b1;
          w_data_nxt  = w_rom;
        end
      end
      ST_DELAY: begin
        // Leaving at 1 (not 0) makes the pause exactly reg_val*DLY_UNIT
        // cycles; a zero-length marker still spends its one cycle here.
        if (r_cnt <= CNT_W'(1)) begin
          w_adv = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (i2c.i2c_done) begin
          if (!i2c.i2c_nack) begin
            w_adv = 1'b1;
          end else if (r_retry < MAX_RETRY) begin
            w_retry_nxt = r_retry + 3'd1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_DONE, ST_ERR: begin
        if (cfg_start) begin
          w_state_nxt = ST_FETCH;
          w_idx_nxt   = 8'd0;
          w_retry_nxt = 3'd0;
        end
      end
      default: begin
        w_state_nxt = ST_PWDN;
        w_cnt_nxt   = LD_PWDN;
      end
    endcase

    if (w_adv) begin
      w_retry_nxt = 3'd0;
      if (r_idx == REG_NUM - 8'd1) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_idx_nxt   = r_idx + 8'd1;
        w_state_nxt = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PWDN;
      r_cnt       <= LD_PWDN;
      r_idx       <= 8'd0;
      r_retry     <= 3'd0;
      r_exec      <= 1'b0;
      r_data      <= '0;
      r_pwdn      <= 1'b1;
      r_rst_n     <= 1'b0;
      r_init_done <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_retry     <= w_retry_nxt;
      r_exec      <= w_exec_nxt;
      r_data      <= w_data_nxt;
      // Pins and flags are registered from the next state so they switch
      // cleanly on the same edge as the state change.
      r_pwdn      <= (w_state_nxt == ST_PWDN);
      r_rst_n     <= !(w_state_nxt inside {ST_PWDN, ST_RSTL});
      r_init_done <= (w_state_nxt == ST_DONE);
      r_cfg_err   <= (w_state_nxt == ST_ERR);
    end
  end

  assign cam_pwdn     = r_pwdn;
  assign cam_rst_n    = r_rst_n;
  assign init_done    = r_init_done;
  assign cfg_err      = r_cfg_err;
  assign cfg_idx      = r_idx;
  assign i2c.i2c_exec = r_exec;
  assign i2c.i2c_data = r_data;

endmodule

// File: tb/tb_cmos_cfg_ctrl.sv
// tb/tb_cmos_cfg_ctrl.sv - directed self-checking bench for cmos_cfg_ctrl

module tb_cmos_cfg_ctrl;

  localparam logic [23:0] ROM0 = 24'h310311;
  localparam logic [23:0] ROM1 = 24'h300882;
  localparam logic [23:0] ROM3 = 24'h300842;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cam_pwdn, cam_rst_n, init_done, cfg_err;
  logic [7:0] cfg_idx;

  cmos_cfg_ctrl_if u_if ();

  cmos_cfg_ctrl #(
    .PWDN_CYC   (4),
    .RST_CYC    (4),
    .SETTLE_CYC (8),
    .REG_NUM    (8'd4),
    .MAX_RETRY  (3'd2),
    .DLY_UNIT   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cam_pwdn  (cam_pwdn),
    .cam_rst_n (cam_rst_n),
    .init_done (init_done),
    .cfg_err   (cfg_err),
    .cfg_idx   (cfg_idx),
    .i2c       (u_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_err = 0;
  int   t0 = 0;
  int   rel = 0;
  int   n_exec, n_toggle, pwdn_fall, rstn_rise, init_rise;
  logic prev_pwdn, prev_rstn, prev_init;
  int   at;
  logic [23:0] d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rel = cyc - t0;
    if (u_if.i2c_exec === 1'b1) n_exec++;
    if (prev_pwdn === 1'b1 && cam_pwdn === 1'b0) pwdn_fall = rel;
    if (prev_rstn === 1'b0 && cam_rst_n === 1'b1) rstn_rise = rel;
    if (prev_init === 1'b0 && init_done === 1'b1) init_rise = rel;
    if (cam_pwdn !== prev_pwdn || cam_rst_n !== prev_rstn) n_toggle++;
    prev_pwdn = cam_pwdn;
    prev_rstn = cam_rst_n;
    prev_init = init_done;
  endtask

  task automatic clear_track();
    n_exec = 0; n_toggle = 0;
    pwdn_fall = -1; rstn_rise = -1; init_rise = -1;
    prev_pwdn = cam_pwdn; prev_rstn = cam_rst_n; prev_init = init_done;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pwdn"},  cam_pwdn, 1);
    chk({tag, "_rstn"},  cam_rst_n, 0);
    chk({tag, "_exec"},  u_if.i2c_exec, 0);
    chk({tag, "_data"},  u_if.i2c_data, 0);
    chk({tag, "_init"},  init_done, 0);
    chk({tag, "_err"},   cfg_err, 0);
    chk({tag, "_idx"},   cfg_idx, 0);
  endtask

  // Holds rst across one edge, checks reset values, releases at cycle 0.
  task automatic do_reset();
    rst = 1'b1; cfg_start = 1'b0;
    u_if.i2c_done = 1'b0; u_if.i2c_nack = 1'b0;
    step();
    chk_reset_outs("rst");
    rst = 1'b0;
    t0 = cyc;
    rel = 0;
    clear_track();
  endtask

  task automatic wait_exec(input int limit, output int a, output logic [23:0] dd);
    a = -1; dd = '0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (u_if.i2c_exec === 1'b1) begin
        a = rel; dd = u_if.i2c_data;
        break;
      end
    end
  endtask

  // Called on the exec cycle; answers 5 cycles later.
  task automatic ack(input logic nk, input bit pulse_start);
    step();
    chk("exec_one_cycle", u_if.i2c_exec, 0);
    for (int i = 0; i < 4; i++) begin
      cfg_start = pulse_start && (i == 1);
      step();
    end
    cfg_start = 1'b0;
    u_if.i2c_done = 1'b1; u_if.i2c_nack = nk;
    step();
    u_if.i2c_done = 1'b0; u_if.i2c_nack = 1'b0;
  endtask

  task automatic power_up_first(input string tag);
    wait_exec(40, at, d);
    chk({tag, "_pwdn_fall"}, pwdn_fall, 4);
    chk({tag, "_rstn_rise"}, rstn_rise, 8);
    chk({tag, "_exec0_cyc"}, at, 17);
    chk({tag, "_exec0_data"}, d, ROM0);
  endtask

  // Entries 1 and 3 acked after entry 0 was acked; the delay marker sits between.
  task automatic finish_nominal(input string tag, input bit start_in_wait);
    ack(1'b0, start_in_wait);
    wait_exec(20, at, d);
    chk({tag, "_exec1_cyc"}, at, 24);
    chk({tag, "_exec1_data"}, d, ROM1);
    ack(1'b0, 1'b0);
    wait_exec(30, at, d);
    chk({tag, "_exec3_cyc"}, at, 38);
    chk({tag, "_exec3_data"}, d, ROM3);
    ack(1'b0, 1'b0);
    chk({tag, "_init_rise"}, init_rise, 44);
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_idx"}, cfg_idx, 3);
    repeat (10) step();
    chk({tag, "_exec_count"}, n_exec, 3);
    chk({tag, "_init_hold"}, init_done, 1);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0;
    u_if.i2c_done = 1'b0; u_if.i2c_nack = 1'b0;
    repeat (2) @(posedge clk);

    // Power sequencing and an all-ack table walk.
    do_reset();
    chk("rel_pins_c0", {30'd0, cam_pwdn, cam_rst_n}, 32'd2);
    power_up_first("a");
    finish_nominal("a", 1'b0);

    // One NACK on entry 1, then acked.
    do_reset();
    power_up_first("b");
    ack(1'b0, 1'b0);
    wait_exec(20, at, d);
    chk("b_exec1_cyc", at, 24);
    ack(1'b1, 1'b0);
    wait_exec(20, at, d);
    chk("b_retry_cyc", at, 31);
    chk("b_retry_data", d, ROM1);
    ack(1'b0, 1'b0);
    wait_exec(30, at, d);
    chk("b_exec3_cyc", at, 45);
    chk("b_exec3_data", d, ROM3);
    ack(1'b0, 1'b0);
    chk("b_init_rise", init_rise, 51);
    chk("b_exec_count", n_exec, 4);

    // Retries exhausted on entry 1, then restart with cfg_start.
    do_reset();
    power_up_first("c");
    ack(1'b0, 1'b0);
    wait_exec(20, at, d);
    chk("c_exec1_cyc", at, 24);
    ack(1'b1, 1'b0);
    wait_exec(20, at, d);
    chk("c_retry1_cyc", at, 31);
    ack(1'b1, 1'b0);
    wait_exec(20, at, d);
    chk("c_retry2_cyc", at, 38);
    ack(1'b1, 1'b0);
    chk("c_err_cyc", rel, 44);
    chk("c_err", cfg_err, 1);
    chk("c_err_idx", cfg_idx, 1);
    chk("c_err_init", init_done, 0);
    repeat (10) step();
    chk("c_err_no_exec", n_exec, 4);
    chk("c_err_hold", cfg_err, 1);
    n_toggle = 0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("c_restart_err", cfg_err, 0);
    chk("c_restart_idx", cfg_idx, 0);
    wait_exec(10, at, d);
    chk("c_restart_exec_cyc", at, 56);
    chk("c_restart_exec_data", d, ROM0);
    chk("c_restart_no_toggle", n_toggle, 0);
    chk("c_restart_rstn", cam_rst_n, 1);

    // Spurious done in SETTLE and cfg_start in WAIT change nothing.
    do_reset();
    repeat (11) step();
    u_if.i2c_done = 1'b1;
    step();
    u_if.i2c_done = 1'b0;
    power_up_first("d");
    finish_nominal("d", 1'b1);

    // Reset while waiting on entry 1, then a late done.
    do_reset();
    power_up_first("e");
    ack(1'b0, 1'b0);
    wait_exec(20, at, d);
    chk("e_exec1_cyc", at, 24);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk_reset_outs("e_mid");
    rst = 1'b0;
    t0 = cyc;
    rel = 0;
    clear_track();
    repeat (2) step();
    u_if.i2c_done = 1'b1;
    step();
    u_if.i2c_done = 1'b0;
    chk("e_late_done_idle", u_if.i2c_exec, 0);
    chk("e_late_done_pwdn", cam_pwdn, 1);
    power_up_first("e2");
    chk("e2_exec_count", n_exec, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
